css_mcu0_el2_ifu_iccm_arb: RTL and testbench
============================================

// Module: css_mcu0_el2_ifu_iccm_arb
// PURPOSE
//  Sequences every access to the ICCM bank array. Arbitrates between IFU fetch reads, DMA reads/writes
//  and ECC single-bit-error (SBE) correction write-backs. Drives iccm_rden/wren/rw_addr/wr_size/wr_data,
//  iccm_buf_correct_ecc and iccm_correction_state of the ICCM memory block. Tags read returns by requester.
// PARAMETERS
//  ICCM_BITS     16  byte-address width of ICCM; addresses are [ICCM_BITS-1:1]
//  DMA_MAX_WAIT  8   consecutive denied DMA cycles before DMA is promoted over fetch (>=1)
// PORTS
//  clk                    in   1   core clock (active_clk domain)
//  rst_l                  in   1   asynchronous active-low reset
//  fetch_req              in   1   IFU read request
//  fetch_addr             in   ICCM_BITS-1  IFU halfword address
//  fetch_gnt              out  1   fetch accepted this cycle
//  dma_req                in   1   DMA request
//  dma_we                 in   1   1=write, 0=read
//  dma_addr               in   ICCM_BITS-1  DMA address
//  dma_size               in   3   size; [1:0]==2'b11 is doubleword
//  dma_wdata              in   78  ECC-encoded write data {hi39,lo39}
//  dma_gnt                out  1   DMA accepted this cycle
//  sbe_valid              in   1   single-bit error on last read, corrected data available
//  sbe_addr               in   ICCM_BITS-1  word address of failing read
//  sbe_data               in   39  corrected, re-encoded word
//  sbe_drop               out  1   pulse: SBE discarded because a correction was already pending
//  rd_valid               out  1   read data on ICCM outputs this cycle
//  rd_tag                 out  1   0=fetch, 1=DMA; valid with rd_valid
//  iccm_rden, iccm_wren   out  1   to ICCM block
//  iccm_rw_addr           out  ICCM_BITS-1  to ICCM block
//  iccm_wr_size           out  3   to ICCM block
//  iccm_wr_data           out  78  to ICCM block
//  iccm_buf_correct_ecc   out  1   correction write cycle
//  iccm_correction_state  out  1   correction sequence in progress
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; starve counter=0; correction buffer invalid.
//  Grants combinational, same cycle as req; at most one ICCM op per cycle; rden&wren never both 1.
//  Priority: CORR_WR > promoted DMA > fetch > DMA. Promoted when starve_cnt==DMA_MAX_WAIT.
//  starve_cnt: +1 per cycle dma_req&~dma_gnt, saturating at DMA_MAX_WAIT; cleared on dma_gnt or ~dma_req.
//  Read latency 1: rd_valid/rd_tag registered from the granted read; writes produce no rd_valid.
//  FSM IDLE->CORR_PEND on sbe_valid (capture addr, data, splat {data,data} into wr_data).
//  CORR_PEND->CORR_WR next cycle unconditionally (one-cycle bubble lets in-flight read retire).
//  CORR_WR: iccm_wren=1, iccm_buf_correct_ecc=1, wr_size=3'b010, rw_addr={sbe_addr[..:2],1'b0};
//    no grants this cycle. ->CORR_HOLD.
//  CORR_HOLD: normal arbitration; ->IDLE on first fetch_gnt to the corrected word or after 4 cycles.
//  iccm_correction_state=1 in CORR_PEND, CORR_WR, CORR_HOLD.
//  sbe_valid outside IDLE: ignored, sbe_drop=1 for that cycle; sbe_valid in same cycle as IDLE->exit
//    not possible (one capture only).
//  DMA write to captured word while CORR_PEND: abort correction (->IDLE), DMA data supersedes.
//  Async reset mid-sequence discards correction; no partial write is issued afterward.
// STRUCTURE
//  Package css_mcu0_el2_pkg: typedef enum {IDLE,CORR_PEND,CORR_WR,CORR_HOLD} iccm_corr_state_e;
//    localparams ICCM_TAG_FETCH=1'b0, ICCM_TAG_DMA=1'b1.
//  Sub-module css_mcu0_el2_ifu_iccm_corr_fsm: correction FSM + capture regs; arb/starve logic in top.
//  All flops css_mcu0_rvdff/rvdffs, async reset on rst_l.
// TESTING
//  fetch_req only, addr 0x0040 -> fetch_gnt=1, rden=1, next cycle rd_valid=1 rd_tag=0.
//  fetch & DMA read every cycle, DMA_MAX_WAIT=8 -> DMA granted exactly on 9th cycle, counter clears.
//  DMA DW write addr 0x0100 size 3'b011 -> wren=1, wr_size=3'b011, wr_data=dma_wdata, no rd_valid.
//  sbe_valid addr 0x0086 data 39'h5A -> cycle+2: wren=1, buf_correct_ecc=1, addr 0x0084,
//    wr_data={39'h5A,39'h5A}; fetch/dma_gnt=0 that cycle; correction_state high 3..7 cycles.
//  second sbe_valid during CORR_HOLD -> sbe_drop=1, no second correction write.
//  rst_l low during CORR_PEND -> all outputs 0 immediately; no correction write after release.

Source files
------------

// File: rtl/css_mcu0_el2_pkg.sv
// css_mcu0_el2_pkg: shared types, read-return tags and word-compare helper for the ICCM arbiter.
package css_mcu0_el2_pkg;
   typedef enum logic [1:0] {IDLE, CORR_PEND, CORR_WR, CORR_HOLD} iccm_corr_state_e;
   localparam logic ICCM_TAG_FETCH = 1'b0;
   localparam logic ICCM_TAG_DMA   = 1'b1;
   // Word addresses; a doubleword access covers both words of an aligned pair.
   function automatic logic iccm_same_word(input logic [31:2] a, input logic [31:2] b, input logic dw);
      return dw ? a[31:3] == b[31:3] : a == b;
   endfunction
endpackage

// File: rtl/css_mcu0_el2_ifu_iccm_arb_if.sv
// css_mcu0_el2_ifu_iccm_arb_if: requester, SBE and ICCM-array signals of the ICCM arbiter.
interface css_mcu0_el2_ifu_iccm_arb_if #(parameter int ICCM_BITS = 16);
   logic                 fetch_req;
   logic [ICCM_BITS-1:1] fetch_addr;
   logic                 fetch_gnt;
   logic                 dma_req;
   logic                 dma_we;
   logic [ICCM_BITS-1:1] dma_addr;
   logic [2:0]           dma_size;
   logic [77:0]          dma_wdata;
   logic                 dma_gnt;
   logic                 sbe_valid;
   logic [ICCM_BITS-1:1] sbe_addr;
   logic [38:0]          sbe_data;
   logic                 sbe_drop;
   logic                 rd_valid;
   logic                 rd_tag;
   logic                 iccm_rden;
   logic                 iccm_wren;
   logic [ICCM_BITS-1:1] iccm_rw_addr;
   logic [2:0]           iccm_wr_size;
   logic [77:0]          iccm_wr_data;
   logic                 iccm_buf_correct_ecc;
   logic                 iccm_correction_state;
   modport master (
      output fetch_req, fetch_addr, dma_req, dma_we, dma_addr, dma_size, dma_wdata,
             sbe_valid, sbe_addr, sbe_data,
      input  fetch_gnt, dma_gnt, sbe_drop, rd_valid, rd_tag, iccm_rden, iccm_wren, iccm_rw_addr,
             iccm_wr_size, iccm_wr_data, iccm_buf_correct_ecc, iccm_correction_state
   );
   modport slave (
      input  fetch_req, fetch_addr, dma_req, dma_we, dma_addr, dma_size, dma_wdata,
             sbe_valid, sbe_addr, sbe_data,
      output fetch_gnt, dma_gnt, sbe_drop, rd_valid, rd_tag, iccm_rden, iccm_wren, iccm_rw_addr,
             iccm_wr_size, iccm_wr_data, iccm_buf_correct_ecc, iccm_correction_state
   );
endinterface

// File: rtl/css_mcu0_el2_ifu_iccm_corr_fsm.sv
// css_mcu0_el2_ifu_iccm_corr_fsm: captures one SBE correction and sequences its write-back.
module css_mcu0_el2_ifu_iccm_corr_fsm
   import css_mcu0_el2_pkg::*;
#(parameter int ICCM_BITS = 16) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 sbe_valid,
   input  logic [ICCM_BITS-1:2] sbe_word,
   input  logic [38:0]          sbe_data,
   input  logic                 dma_wr,
   input  logic                 dma_dw,
   input  logic [ICCM_BITS-1:2] dma_word,
   input  logic                 fetch_gnt,
   input  logic [ICCM_BITS-1:2] fetch_word,
   output logic                 corr_wr,
   output logic                 corr_active,
   output logic                 sbe_drop,
   output logic [ICCM_BITS-1:1] corr_addr,
   output logic [38:0]          corr_data
);
   logic [1:0]           state_q, hold_q, hold_nxt;
   logic                 cap;
   logic [ICCM_BITS-1:2] word_q;
   iccm_corr_state_e     state, state_nxt;
   assign state = iccm_corr_state_e'(state_q);
   always_comb begin
      state_nxt = state;
      hold_nxt  = '0;
      cap       = 1'b0;
      case (state)
         IDLE: begin
            cap       = sbe_valid;
            state_nxt = sbe_valid ? CORR_PEND : IDLE;
         end
         // A DMA write landing on the captured word makes the correction stale.
         CORR_PEND: state_nxt = (dma_wr && iccm_same_word(30'(dma_word), 30'(word_q), dma_dw)) ? IDLE : CORR_WR;
         CORR_WR:   state_nxt = CORR_HOLD;
         CORR_HOLD: begin
            hold_nxt  = hold_q + 2'd1;
            state_nxt = ((fetch_gnt && iccm_same_word(30'(fetch_word), 30'(word_q), 1'b0)) || hold_q == 2'd3) ? IDLE : CORR_HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end
   css_mcu0_rvdff  #(.WIDTH(2))           state_ff (.clk(clk), .rst_l(rst_l), .din(state_nxt), .dout(state_q));
   css_mcu0_rvdff  #(.WIDTH(2))           hold_ff  (.clk(clk), .rst_l(rst_l), .din(hold_nxt), .dout(hold_q));
   css_mcu0_rvdffs #(.WIDTH(ICCM_BITS-2)) addr_ff  (.clk(clk), .rst_l(rst_l), .en(cap), .din(sbe_word), .dout(word_q));
   css_mcu0_rvdffs #(.WIDTH(39))          data_ff  (.clk(clk), .rst_l(rst_l), .en(cap), .din(sbe_data), .dout(corr_data));
   assign corr_wr     = state == CORR_WR;
   assign corr_active = state != IDLE;
   assign sbe_drop    = sbe_valid & corr_active;
   assign corr_addr   = {word_q, 1'b0};
endmodule

// File: rtl/css_mcu0_rvdff.sv
// css_mcu0_rvdff: plain flop bank with asynchronous active-low clear.
module css_mcu0_rvdff #(parameter int WIDTH = 1) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) dout <= '0;
      else dout <= din;
endmodule

// File: rtl/css_mcu0_rvdffs.sv
// css_mcu0_rvdffs: enabled flop bank with asynchronous active-low clear.
module css_mcu0_rvdffs #(parameter int WIDTH = 1) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) dout <= '0;
      else if (en) dout <= din;
endmodule

// File: rtl/css_mcu0_el2_ifu_iccm_arb.sv
// css_mcu0_el2_ifu_iccm_arb: single-port ICCM arbiter for fetch, DMA and ECC correction write-backs.
module css_mcu0_el2_ifu_iccm_arb
   import css_mcu0_el2_pkg::*;
#(
   parameter int ICCM_BITS    = 16,
   parameter int DMA_MAX_WAIT = 8
) (
   input logic clk,
   input logic rst_l,
   css_mcu0_el2_ifu_iccm_arb_if.slave bus
);
   localparam int CW = $clog2(DMA_MAX_WAIT + 1);
   logic [CW-1:0]        starve_cnt, starve_nxt;
   logic                 promoted, fetch_gnt, dma_gnt, dma_rd, dma_wr, rden;
   logic                 corr_wr, corr_active, sbe_drop;
   logic [1:0]           rd_q;
   logic [ICCM_BITS-1:1] corr_addr;
   logic [38:0]          corr_data;
   // Grants are held low while in reset so the array sees no access.
   always_comb begin
      promoted   = starve_cnt == CW'(DMA_MAX_WAIT);
      dma_gnt    = rst_l & ~corr_wr & bus.dma_req & (promoted | ~bus.fetch_req);
      fetch_gnt  = rst_l & ~corr_wr & bus.fetch_req & ~(bus.dma_req & promoted);
      dma_rd     = dma_gnt & ~bus.dma_we;
      dma_wr     = dma_gnt & bus.dma_we;
      rden       = fetch_gnt | dma_rd;
      starve_nxt = (~bus.dma_req | dma_gnt) ? '0 : promoted ? starve_cnt : starve_cnt + CW'(1);
   end
   css_mcu0_rvdff #(.WIDTH(CW)) starve_ff (.clk(clk), .rst_l(rst_l), .din(starve_nxt), .dout(starve_cnt));
   css_mcu0_rvdff #(.WIDTH(2))  rd_ff     (.clk(clk), .rst_l(rst_l),
                                           .din({rden, dma_rd ? ICCM_TAG_DMA : ICCM_TAG_FETCH}), .dout(rd_q));
   css_mcu0_el2_ifu_iccm_corr_fsm #(.ICCM_BITS(ICCM_BITS)) corr (
      .clk(clk), .rst_l(rst_l),
      .sbe_valid(bus.sbe_valid), .sbe_word(bus.sbe_addr[ICCM_BITS-1:2]), .sbe_data(bus.sbe_data),
      .dma_wr(dma_wr), .dma_dw(bus.dma_size[1:0] == 2'b11), .dma_word(bus.dma_addr[ICCM_BITS-1:2]),
      .fetch_gnt(fetch_gnt), .fetch_word(bus.fetch_addr[ICCM_BITS-1:2]),
      .corr_wr(corr_wr), .corr_active(corr_active), .sbe_drop(sbe_drop),
      .corr_addr(corr_addr), .corr_data(corr_data)
   );
   assign bus.fetch_gnt             = fetch_gnt;
   assign bus.dma_gnt               = dma_gnt;
   assign bus.sbe_drop              = sbe_drop;
   assign bus.rd_valid              = rd_q[1];
   assign bus.rd_tag                = rd_q[0];
   assign bus.iccm_rden             = rden;
   assign bus.iccm_wren             = corr_wr | dma_wr;
   assign bus.iccm_rw_addr          = corr_wr ? corr_addr : dma_gnt ? bus.dma_addr : fetch_gnt ? bus.fetch_addr : '0;
   assign bus.iccm_wr_size          = corr_wr ? 3'b010 : dma_wr ? bus.dma_size : 3'b000;
   assign bus.iccm_wr_data          = corr_wr ? {corr_data, corr_data} : dma_wr ? bus.dma_wdata : '0;
   assign bus.iccm_buf_correct_ecc  = corr_wr;
   assign bus.iccm_correction_state = corr_active;
endmodule

// File: tb/tb_css_mcu0_el2_ifu_iccm_arb.sv
// tb_css_mcu0_el2_ifu_iccm_arb: directed and random checks against a cycle-age reference model.
module tb_css_mcu0_el2_ifu_iccm_arb;
   import css_mcu0_el2_pkg::*;
   localparam int IB = 16, MW = 8;
   logic clk = 1'b0, rst_l = 1'b0;
   always #5 clk = ~clk;
   css_mcu0_el2_ifu_iccm_arb_if #(.ICCM_BITS(IB)) bus ();
   css_mcu0_el2_ifu_iccm_arb #(.ICCM_BITS(IB), .DMA_MAX_WAIT(MW)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));
   int errors = 0, checks = 0;
   logic freq, dreq, dwe, sv;
   logic [15:0] fb, db, sb;
   logic [2:0] dsz;
   logic [77:0] dwd;
   logic [38:0] sd;
   int starve, cyc, t0, age;
   bit con, wrc, eg_f, eg_d, e_rden, rv_e, tag_e;
   logic [15:0] cb, e_addr;
   logic [38:0] cd;
   logic [2:0] e_size;
   logic [77:0] e_data;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic idle;
      freq = 0; dreq = 0; dwe = 0; sv = 0; fb = 0; db = 0; sb = 0; dsz = 0; dwd = '0; sd = '0;
   endtask
   task automatic drive;
      bus.fetch_req = freq; bus.fetch_addr = fb[15:1];
      bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = db[15:1]; bus.dma_size = dsz; bus.dma_wdata = dwd;
      bus.sbe_valid = sv; bus.sbe_addr = sb[15:1]; bus.sbe_data = sd;
   endtask
   task automatic model_reset;
      starve = 0; cyc = 0; con = 0; t0 = 0;
   endtask
   // Drive this cycle's inputs and check everything combinational against the model.
   task automatic apply;
      drive;
      #1;
      age    = con ? cyc - t0 : 0;
      wrc    = con && age == 2;
      eg_d   = !wrc && dreq && (starve >= MW || !freq);
      eg_f   = !wrc && freq && !(dreq && starve >= MW);
      e_rden = eg_f || (eg_d && !dwe);
      e_addr = wrc ? cb : eg_d ? db : eg_f ? fb : 16'h0;
      e_size = wrc ? 3'b010 : (eg_d && dwe) ? dsz : 3'b000;
      e_data = wrc ? {cd, cd} : (eg_d && dwe) ? dwd : 78'h0;
      chk("fetch_gnt", bus.fetch_gnt, eg_f);
      chk("dma_gnt", bus.dma_gnt, eg_d);
      chk("rden", bus.iccm_rden, e_rden);
      chk("wren", bus.iccm_wren, wrc || (eg_d && dwe));
      chk("rw_addr", bus.iccm_rw_addr, e_addr[15:1]);
      chk("wr_size", bus.iccm_wr_size, e_size);
      chk("wr_data", bus.iccm_wr_data, e_data);
      chk("buf_ecc", bus.iccm_buf_correct_ecc, wrc);
      chk("corr_state", bus.iccm_correction_state, con);
      chk("sbe_drop", bus.sbe_drop, sv && con);
   endtask
   // Advance the model one clock and check the registered read return.
   task automatic adv;
      if (!con && sv) begin
         con = 1; t0 = cyc; cb = sb & 16'hFFFC; cd = sd;
      end else if (con) begin
         if (age == 1 && eg_d && dwe && ((dsz[1:0] == 2'b11) ? (db >> 3) == (cb >> 3) : (db >> 2) == (cb >> 2))) con = 0;
         else if (age >= 3 && ((eg_f && (fb >> 2) == (cb >> 2)) || age == 6)) con = 0;
      end
      starve = (!dreq || eg_d) ? 0 : (starve < MW ? starve + 1 : MW);
      rv_e = e_rden;
      tag_e = eg_d && !dwe;
      cyc++;
      @(posedge clk);
      #1;
      chk("rd_valid", bus.rd_valid, rv_e);
      chk("rd_tag", bus.rd_tag, tag_e);
   endtask
   initial begin
      bit g[10];
      int n;
      idle;
      drive;
      #12;
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
      chk("rst_rden", bus.iccm_rden, 1'b0);
      chk("rst_wren", bus.iccm_wren, 1'b0);
      chk("rst_corr_state", bus.iccm_correction_state, 1'b0);
      chk("rst_rw_addr", bus.iccm_rw_addr, 15'h0);
      @(negedge clk) rst_l = 1'b1;
      @(posedge clk);
      #1;
      model_reset;
      // Plain fetch read.
      idle; freq = 1; fb = 16'h0040;
      apply;
      chk("t1_gnt", bus.fetch_gnt, 1'b1);
      chk("t1_rden", bus.iccm_rden, 1'b1);
      chk("t1_addr", bus.iccm_rw_addr, 15'h0020);
      adv;
      chk("t1_rd_valid", bus.rd_valid, 1'b1);
      chk("t1_rd_tag", bus.rd_tag, ICCM_TAG_FETCH);
      // DMA starvation and promotion.
      idle; freq = 1; dreq = 1; fb = 16'h0010; db = 16'h0020;
      for (int i = 0; i < 10; i++) begin
         apply;
         g[i] = bus.dma_gnt;
         adv;
      end
      for (int i = 0; i < 10; i++) chk($sformatf("t2_dma_gnt_%0d", i), g[i], i == 8);
      // Doubleword DMA write.
      idle; dreq = 1; dwe = 1; db = 16'h0100; dsz = 3'b011; dwd = {14'($urandom), $urandom, $urandom};
      apply;
      chk("t3_wren", bus.iccm_wren, 1'b1);
      chk("t3_rden", bus.iccm_rden, 1'b0);
      chk("t3_size", bus.iccm_wr_size, 3'b011);
      chk("t3_data", bus.iccm_wr_data, dwd);
      adv;
      chk("t3_no_rd_valid", bus.rd_valid, 1'b0);
      // SBE correction sequence.
      idle; sv = 1; sb = 16'h0086; sd = 39'h5A;
      apply; adv;
      idle; freq = 1; fb = 16'h0300; dreq = 1; db = 16'h0400;
      apply;
      n = int'(bus.iccm_correction_state);
      adv;
      apply;
      chk("t4_wren", bus.iccm_wren, 1'b1);
      chk("t4_ecc", bus.iccm_buf_correct_ecc, 1'b1);
      chk("t4_addr", bus.iccm_rw_addr, 15'h0042);
      chk("t4_size", bus.iccm_wr_size, 3'b010);
      chk("t4_data", bus.iccm_wr_data, {39'h5A, 39'h5A});
      chk("t4_fetch_gnt", bus.fetch_gnt, 1'b0);
      chk("t4_dma_gnt", bus.dma_gnt, 1'b0);
      n += int'(bus.iccm_correction_state);
      adv;
      idle; freq = 1; fb = 16'h0300;
      for (int i = 0; i < 8; i++) begin
         apply;
         n += int'(bus.iccm_correction_state);
         adv;
      end
      chk("t4_corr_len", n >= 3 && n <= 7, 1'b1);
      // Second SBE while holding is dropped.
      idle; sv = 1; sb = 16'h0200; sd = 39'h1234;
      apply; adv;
      idle;
      apply; adv;
      apply; adv;
      sv = 1; sb = 16'h0280; sd = 39'h777;
      apply;
      chk("t5_drop", bus.sbe_drop, 1'b1);
      adv;
      idle;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         apply;
         n += int'(bus.iccm_buf_correct_ecc);
         adv;
      end
      chk("t5_no_second_write", n, 0);
      // DMA write to the pending word aborts the correction.
      idle; sv = 1; sb = 16'h0110; sd = 39'h3C3;
      apply; adv;
      idle; dreq = 1; dwe = 1; db = 16'h0112; dsz = 3'b010; dwd = 78'h5;
      apply;
      chk("t6_dma_gnt", bus.dma_gnt, 1'b1);
      adv;
      idle;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         apply;
         n += int'(bus.iccm_buf_correct_ecc);
         adv;
      end
      chk("t6_aborted", n, 0);
      // Asynchronous reset while the correction is pending.
      idle; sv = 1; sb = 16'h0180; sd = 39'h11; freq = 1; fb = 16'h0040;
      apply; adv;
      idle; freq = 1; fb = 16'h0040;
      drive;
      rst_l = 1'b0;
      #1;
      chk("t7_fetch_gnt", bus.fetch_gnt, 1'b0);
      chk("t7_rden", bus.iccm_rden, 1'b0);
      chk("t7_rd_valid", bus.rd_valid, 1'b0);
      chk("t7_corr_state", bus.iccm_correction_state, 1'b0);
      chk("t7_wren", bus.iccm_wren, 1'b0);
      chk("t7_rw_addr", bus.iccm_rw_addr, 15'h0);
      @(negedge clk);
      @(negedge clk) rst_l = 1'b1;
      @(posedge clk);
      #1;
      model_reset;
      idle;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         apply;
         n += int'(bus.iccm_buf_correct_ecc);
         adv;
      end
      chk("t7_no_write", n, 0);
      // Random traffic over a small address window so words collide often.
      for (int i = 0; i < 600; i++) begin
         freq = ($urandom % 4) != 0;
         fb   = 16'h0080 | 16'($urandom % 8) << 1;
         dreq = ($urandom % 3) == 0;
         dwe  = $urandom % 2;
         db   = 16'h0080 | 16'($urandom % 8) << 1;
         dsz  = ($urandom % 4 == 0) ? 3'b011 : 3'b010;
         dwd  = {14'($urandom), $urandom, $urandom};
         sv   = ($urandom % 10) == 0;
         sb   = 16'h0080 | 16'($urandom % 8) << 1;
         sd   = {7'($urandom), $urandom};
         apply;
         adv;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
